// File: rtl/key_expansion_if.sv
// key_expansion_if: start/finish handshake and expanded-key bus of the AES-128 key schedule.
interface key_expansion_if;
   logic [127:0]  cipher_key;
   logic          start;
   logic [1407:0] expanded_key;
   logic          busy;
   logic          finish;
   logic          key_valid;
   modport master (output cipher_key, start, input expanded_key, busy, finish, key_valid);
   modport slave  (input cipher_key, start, output expanded_key, busy, finish, key_valid);
endinterface

// File: rtl/key_expansion.sv
// key_expansion: iterative AES-128 key schedule, one 32-bit word per clock, 40 cycles per key.
module key_expansion (
   input logic            clk,
   input logic            rst,
   key_expansion_if.slave bus
);
   typedef enum logic {IDLE, EXPAND} state_t;
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16};
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction
   function automatic logic [7:0] rcon(input logic [3:0] k);
      case (k)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction
   state_t        r_state, w_next;
   logic [5:0]    r_idx;
   logic [1407:0] r_key;
   logic          r_busy, r_finish, r_valid;
   logic [31:0]   w_prev, w_back, w_rot, w_temp, w_new;
   // Word i lives at bit offset 32*(i^3): round i/4, with w[4r] in the top lane.
   always_comb begin
      w_prev = r_key[{(r_idx - 6'd1) ^ 6'd3, 5'd0} +: 32];
      w_back = r_key[{(r_idx - 6'd4) ^ 6'd3, 5'd0} +: 32];
      w_rot  = {w_prev[23:0], w_prev[31:24]};
      w_temp = (r_idx[1:0] == 2'd0)
             ? {sbox(w_rot[31:24]) ^ rcon(r_idx[5:2]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
             : w_prev;
      w_new  = w_back ^ w_temp;
      w_next = (r_state == IDLE) ? (bus.start ? EXPAND : IDLE) : ((r_idx == 6'd43) ? IDLE : EXPAND);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_key    <= '0;
         r_busy   <= 1'b0;
         r_finish <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE) begin
            r_finish <= 1'b0;
            if (bus.start) begin
               r_key[127:0] <= bus.cipher_key;
               r_idx        <= 6'd4;
               r_busy       <= 1'b1;
               r_valid      <= 1'b0;
            end
         end else begin
            r_key[{r_idx ^ 6'd3, 5'd0} +: 32] <= w_new;
            r_idx <= r_idx + 6'd1;
            if (r_idx == 6'd43) begin
               r_finish <= 1'b1;
               r_busy   <= 1'b0;
               r_valid  <= 1'b1;
            end
         end
      end
   end
   assign bus.expanded_key = r_key;
   assign bus.busy         = r_busy;
   assign bus.finish       = r_finish;
   assign bus.key_valid    = r_valid;
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: directed + random checks of the AES-128 key schedule against a GF(2^8)-derived model.
module tb_key_expansion;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [7:0] sb [256];
   localparam logic [127:0] KA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   key_expansion_if kif ();
   key_expansion dut (.clk(clk), .rst(rst), .bus(kif));
   always #5 clk = ~clk;
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction
   function automatic logic [7:0] rotl(logic [7:0] x, int n);
      for (int k = 0; k < n; k++) x = {x[6:0], x[7]};
      return x;
   endfunction
   // S-box from first principles: multiplicative inverse then affine map.
   task automatic build_sbox();
      for (int b = 0; b < 256; b++) begin
         logic [7:0] inv = 8'h00;
         for (int x = 1; x < 256; x++)
            if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
         sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask
   function automatic logic [1407:0] model(logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc = 8'h01;
      logic [1407:0] e = '0;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) e[128*(i/4) + 32*(3 - i%4) +: 32] = w[i];
      return e;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic chk_key(input string tag, input logic [1407:0] exp);
      for (int r = 0; r < 11; r++)
         chk($sformatf("%s_rk%0d", tag, r), kif.expanded_key[128*r +: 128], exp[128*r +: 128]);
   endtask
   task automatic chk_flags(input string tag, input logic b, input logic f, input logic v);
      chk({tag, "_busy"}, 128'(kif.busy), 128'(b));
      chk({tag, "_finish"}, 128'(kif.finish), 128'(f));
      chk({tag, "_valid"}, 128'(kif.key_valid), 128'(v));
   endtask
   task automatic do_start(input logic [127:0] key);
      kif.cipher_key = key;
      kif.start = 1'b1;
      tick();
      kif.start = 1'b0;
   endtask
   task automatic wait_finish(input string tag);
      int c = 0;
      do begin
         tick();
         c++;
      end while (!kif.finish && c < 100);
      chk({tag, "_latency"}, 128'(c), 128'd40);
   endtask
   initial begin
      logic [127:0] k;
      int fin_cnt, fin_first, bad;
      kif.start = 1'b0;
      kif.cipher_key = '0;
      build_sbox();
      tick();
      tick();
      rst = 1'b0;
      chk_key("reset", '0);
      chk_flags("reset", 1'b0, 1'b0, 1'b0);
      // FIPS-197 A.1
      do_start(KA1);
      chk_flags("a1_start", 1'b1, 1'b0, 1'b0);
      wait_finish("a1");
      chk("a1_rk1", kif.expanded_key[255:128], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("a1_rk10", kif.expanded_key[1407:1280], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("a1_rk0", kif.expanded_key[127:0], KA1);
      chk_flags("a1_done", 1'b0, 1'b1, 1'b1);
      chk_key("a1_model", model(KA1));
      tick();
      chk_flags("a1_pulse", 1'b0, 1'b0, 1'b1);
      // all-zero key
      do_start('0);
      wait_finish("zero");
      chk("zero_rk1", kif.expanded_key[255:128], 128'h62636363626363636263636362636363);
      chk("zero_rk10", kif.expanded_key[1407:1280], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      // handshake: re-pulsed start and changing key ignored
      do_start(KA1);
      fin_cnt = 0;
      fin_first = 0;
      for (int c = 1; c <= 60; c++) begin
         kif.start = (c == 5 || c == 20);
         if (c == 10 || c == 20) kif.cipher_key = {$urandom, $urandom, $urandom, $urandom};
         tick();
         if (kif.finish) begin
            fin_cnt++;
            if (fin_first == 0) fin_first = c;
         end
      end
      kif.start = 1'b0;
      chk("hs_finish_count", 128'(fin_cnt), 128'd1);
      chk("hs_finish_cycle", 128'(fin_first), 128'd40);
      chk_key("hs", model(KA1));
      // random keys, ending back-to-back with a zero key started in the finish cycle
      for (int n = 0; n < 3; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         do_start(k);
         wait_finish($sformatf("rnd%0d", n));
         chk_key($sformatf("rnd%0d", n), model(k));
      end
      do_start('0);
      chk_flags("b2b_edge", 1'b1, 1'b0, 1'b0);
      wait_finish("b2b");
      chk_key("b2b", model('0));
      // reset mid-operation
      k = {$urandom, $urandom, $urandom, $urandom};
      do_start(k);
      repeat (16) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_key("midrst", '0);
      chk_flags("midrst", 1'b0, 1'b0, 1'b0);
      fin_cnt = 0;
      repeat (60) begin
         tick();
         if (kif.finish) fin_cnt++;
      end
      chk("midrst_no_finish", 128'(fin_cnt), 128'd0);
      do_start(k);
      wait_finish("post_rst");
      chk_key("post_rst", model(k));
      // idle hold
      bad = 0;
      fin_cnt = 0;
      repeat (100) begin
         tick();
         if (kif.expanded_key !== model(k) || kif.key_valid !== 1'b1) bad++;
         if (kif.finish) fin_cnt++;
      end
      chk("hold_changes", 128'(bad), 128'd0);
      chk("hold_finish", 128'(fin_cnt), 128'd0);
      chk_flags("hold", 1'b0, 1'b0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/key_expansion.md
Name: key_expansion

Overview:
- Iterative AES-128 key schedule generator. It produces the 1408-bit expanded key (11 round keys) that the round-key XOR stage consumes through its key bus.
- The block sits upstream of the round datapath and uses the same start/finish pulse handshake as the other round stages.
- It computes one 32-bit schedule word per clock, using a single SubWord path of four S-box byte lookups.

Parameters:
- None. AES-128 is fixed: Nk=4, Nr=10, 44 words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- cipher_key  input  128  cipher key; byte 0 is in [127:120]
- start  input  1  single-cycle request; sampled only in IDLE
- expanded_key  output  1408  round key r is in [128r+127:128r]; within a round key, w[4r] is in [127:96] and w[4r+3] is in [31:0]
- busy  output  1  high while expansion is in progress
- finish  output  1  one-cycle pulse when expansion completes
- key_valid  output  1  expanded_key is complete and stable

Behaviour:
- Reset: on rst=1 at a rising edge, the block clears the following on that edge regardless of state, including mid-expansion:
  - expanded_key, busy, finish, key_valid all to 0
  - word index to 0
  - state to IDLE
- States: IDLE, EXPAND.
- IDLE:
  - If start=1 at edge T: cipher_key is written to round-key slot 0, word index i=4, busy=1, key_valid=0, state goes to EXPAND.
  - If start=0: outputs hold and finish=0.
- cipher_key is sampled only at edge T. Later changes to it do not affect the expansion in progress.
- EXPAND, on each edge:
  - temp = w[i-1].
  - If i mod 4 = 0: temp = SubWord(RotWord(temp)) XOR {Rcon[i/4], 24'h0}.
  - w[i] = w[i-4] XOR temp; w[i] is written into its slot in expanded_key; i increments.
  - RotWord rotates bytes left by one: {b1,b2,b3,b0}.
  - SubWord applies the AES forward S-box to each byte.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Completion: the edge that writes w[43] (edge T+40) also:
  - sets finish=1, busy=0, key_valid=1
  - returns the state to IDLE
- Latency: finish is high for the cycle following edge T+40, i.e. 40 cycles after the start-sampling edge. The finish pulse is exactly one cycle wide.
- start while busy: ignored. There is no queueing and no restart mid-run.
- start in the same cycle finish is high: accepted (the block is already IDLE). That edge clears key_valid and finish and begins a new expansion.
- Back-to-back requests: one expansion per 41 cycles at most.
- During EXPAND: expanded_key updates word by word and is not valid. Consumers gate on key_valid or finish.
- After completion: expanded_key and key_valid hold indefinitely until the next accepted start or reset.
- S-box: a combinational function, used in four parallel instances on the temp bytes. No memory macros.

Test Plan:
- FIPS-197 A.1 vector:
  - Stimulus: cipher_key=2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - Required: finish exactly 40 cycles after the start edge.
  - Required: expanded_key[255:128]=a0fafe1788542cb123a339392a6c7605.
  - Required: expanded_key[1407:1280]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: expanded_key[127:0]=cipher_key; key_valid=1; busy=0.
- All-zero key:
  - Stimulus: cipher_key=0, start pulse.
  - Required: expanded_key[255:128]=62636363626363636263636362636363.
  - Required: expanded_key[1407:1280]=b4ef5bcb3e92e21123e951cf6f8f188e.
- Handshake:
  - Stimulus: start re-pulsed at cycles 5 and 20 of an expansion; cipher_key changed mid-run.
  - Required: both pulses ignored; result identical to the undisturbed A.1 run; a single finish pulse.
- Back-to-back:
  - Stimulus: start asserted in the finish cycle with the zero key.
  - Required: key_valid drops on that edge; a second finish follows 40 cycles later with the zero-key result.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle at cycle 17 of an expansion.
  - Required: next cycle shows expanded_key=0, busy=0, finish=0, key_valid=0, state IDLE.
  - Required: no finish pulse follows; a fresh start then completes normally.
- Idle hold:
  - Stimulus: no start for 100 cycles after completion.
  - Required: expanded_key and key_valid=1 unchanged; finish stays 0.
